// File: rtl/core_pkg.sv
// Shared definitions for the RV32I pipeline sequencer: FSM states, forwarding selects, register-index width.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package core_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // True when a consumer register really depends on a producer's write; x0 never matches.
  function automatic logic reg_hit(input logic [REG_W-1:0] rs, input logic rs_en,
                                   input logic [REG_W-1:0] rd, input logic rd_wr);
    return rs_en & rd_wr & (rd != '0) & (rs == rd);
  endfunction

endpackage

// File: rtl/fwd_unit.sv
// ALU operand bypass select for one EX-stage source register.
// Latency: purely combinational, same cycle.
// Backpressure: none; the select simply follows the current pipeline contents.
module fwd_unit
  import core_pkg::*;
(
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_wr,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_wr,
  output logic [1:0]       sel
);

  // Youngest producer wins: the EX/MEM result is newer than the MEM/WB one.
  always_comb begin
    sel = FWD_RF;
    if (reg_hit(ex_rs, 1'b1, mem_rd, mem_reg_wr)) begin
      sel = FWD_EXMEM;
    end else if (reg_hit(ex_rs, 1'b1, wb_rd, wb_reg_wr)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: PC/pipeline-register enables and flushes, EX forwarding selects, stall counter.
// Latency: controls are combinational from inputs and registered state; state/counters update on clk.
// Backpressure: a pending data-memory access freezes the whole pipe; a timed-out access halts it until reset.
// Optional macro FORWARDING_EN: enables the fwd_unit bypass; without it every RAW hazard on EX/MEM stalls.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_reg_wr,
  input  logic             ex_mem_rd,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_wr,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_wr,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              freeze;
  logic              load_use;
  logic [1:0]        sel_a, sel_b;

  // A pending access freezes everything; once halted, the halt outputs take over instead.
  assign freeze = dmem_req & ~dmem_ready & (state != HALT);

`ifdef FORWARDING_EN
  fwd_unit u_fwd_a (
    .ex_rs      (ex_rs1),
    .mem_rd     (mem_rd),
    .mem_reg_wr (mem_reg_wr),
    .wb_rd      (wb_rd),
    .wb_reg_wr  (wb_reg_wr),
    .sel        (sel_a)
  );

  fwd_unit u_fwd_b (
    .ex_rs      (ex_rs2),
    .mem_rd     (mem_rd),
    .mem_reg_wr (mem_reg_wr),
    .wb_rd      (wb_rd),
    .wb_reg_wr  (wb_reg_wr),
    .sel        (sel_b)
  );

  // Only a load's data is too late to bypass into the next instruction.
  assign load_use = ex_mem_rd & (reg_hit(id_rs1, id_use_rs1, ex_rd, 1'b1) |
                                 reg_hit(id_rs2, id_use_rs2, ex_rd, 1'b1));

  logic unused_fwd_mode;
  assign unused_fwd_mode = ex_reg_wr;
`else
  assign sel_a = FWD_RF;
  assign sel_b = FWD_RF;

  // No bypass: any pending write in EX or MEM must retire first. WB writes the
  // register file in the first half-cycle, so it never needs a stall.
  assign load_use = reg_hit(id_rs1, id_use_rs1, ex_rd, ex_reg_wr | ex_mem_rd) |
                    reg_hit(id_rs2, id_use_rs2, ex_rd, ex_reg_wr | ex_mem_rd) |
                    reg_hit(id_rs1, id_use_rs1, mem_rd, mem_reg_wr) |
                    reg_hit(id_rs2, id_use_rs2, mem_rd, mem_reg_wr);

  logic unused_fwd_mode;
  assign unused_fwd_mode = ^{ex_rs1, ex_rs2, wb_rd, wb_reg_wr};
`endif

  // Next-state: wait_cnt counts the consecutive wait cycles, including the one seen in RUN.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      RUN: begin
        wait_nxt = '0;
        if (dmem_req && !dmem_ready) begin
          if (MEM_TIMEOUT <= 1) begin
            state_nxt = HALT;
          end else begin
            state_nxt = MEM_WAIT;
            wait_nxt  = WAIT_W'(1);
          end
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end else if (int'(wait_cnt) + 1 >= MEM_TIMEOUT) begin
          state_nxt = HALT;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  // Priority: reset/halt, then freeze, then redirect, then hazard stall.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (!rst_n || state == HALT) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (freeze) begin
      // The redirect (if any) stays held in EX and is acted on once the freeze lifts.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign fwd_a = rst_n ? sel_a : FWD_RF;
  assign fwd_b = rst_n ? sel_b : FWD_RF;

  // State, wait counter, sticky halt flag and saturating stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      halted    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      halted   <= halted | (state_nxt == HALT);
      if (!pc_en && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic against a reference model.
// Honors FORWARDING_EN the same way the design does.
module tb_hazard_ctrl;

  localparam int TMO = 15;
  localparam int CW  = 8;
  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush}
  localparam logic [6:0] C_HALT   = 7'b0000111;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_REDIR  = 7'b1111110;
  localparam logic [6:0] C_STALL  = 7'b0011010;
  localparam logic [6:0] C_RUN    = 7'b1111000;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_reg_wr, ex_mem_rd, mem_reg_wr, wb_reg_wr;
  logic ex_redirect, dmem_req, dmem_ready;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush;
  logic [1:0] fwd_a, fwd_b;
  logic halted;
  logic [CW-1:0] stall_cnt;
  logic [6:0] ctrl;

  int checks = 0;
  int errors = 0;

  // Reference model state: consecutive wait cycles, sticky halt, stall cycles.
  int m_waits;
  bit m_halted;
  int m_stalls;

  always #5 clk = ~clk;

  assign ctrl = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_flush};

  hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd),
    .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr), .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr),
    .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .stall_cnt(stall_cnt)
  );

  // ---------------- reference model ----------------
  function automatic bit m_hazard();
    logic [4:0] producers[$];
    bit hit = 1'b0;
`ifdef FORWARDING_EN
    if (ex_mem_rd) producers.push_back(ex_rd);
`else
    if (ex_reg_wr || ex_mem_rd) producers.push_back(ex_rd);
    if (mem_reg_wr) producers.push_back(mem_rd);
`endif
    foreach (producers[i]) begin
      if (producers[i] != 0 && ((id_use_rs1 && id_rs1 == producers[i]) ||
                                (id_use_rs2 && id_rs2 == producers[i])))
        hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [6:0] m_ctrl();
    if (m_halted) return C_HALT;
    if (dmem_req && !dmem_ready) return C_FREEZE;
    if (ex_redirect) return C_REDIR;
    if (m_hazard()) return C_STALL;
    return C_RUN;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
`ifdef FORWARDING_EN
    if (mem_reg_wr && mem_rd != 0 && mem_rd == rs) return 2'b10;
    if (wb_reg_wr && wb_rd != 0 && wb_rd == rs) return 2'b01;
`endif
    return 2'b00;
  endfunction

  task automatic model_clock();
    logic [6:0] c;
    c = m_ctrl();
    if (!c[6] && m_stalls < (1 << CW) - 1) m_stalls++;
    if (!m_halted) begin
      if (!dmem_ready && (dmem_req || m_waits > 0)) begin
        m_waits++;
        if (m_waits >= TMO) m_halted = 1'b1;
      end else begin
        m_waits = 0;
      end
    end
  endtask

  task automatic model_reset();
    m_waits = 0;
    m_halted = 1'b0;
    m_stalls = 0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    id_rs1 = 5'd1; id_rs2 = 5'd2; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rs1 = 5'd3; ex_rs2 = 5'd4; ex_rd = 5'd0; ex_reg_wr = 1'b0; ex_mem_rd = 1'b0;
    mem_rd = 5'd0; mem_reg_wr = 1'b0; wb_rd = 5'd0; wb_reg_wr = 1'b0;
    ex_redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    ex_rs1 = 5'd7; mem_rd = 5'd7; mem_reg_wr = 1'b1; dmem_req = 1'b1; ex_redirect = 1'b1;
    #3;
    checks++; if (ctrl !== C_HALT) begin errors++; $display("FAIL reset_ctrl got %b want %b", ctrl, C_HALT); end
    checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL reset_fwd_a got %b want 00", fwd_a); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    model_reset();
    #1;
    checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL reset_release_ctrl got %b want %b", ctrl, C_RUN); end
    @(posedge clk); #2;
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_first_edge_cnt got %0d want 0", stall_cnt); end
  endtask

  task automatic test_load_use();
    pulse_reset();
    ex_mem_rd = 1'b1; ex_reg_wr = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    #1;
    checks++; if (ctrl !== C_STALL) begin errors++; $display("FAIL load_use_ctrl got %b want %b", ctrl, C_STALL); end
    tick();
    idle_inputs();
    #1;
    checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL load_use_after got %b want %b", ctrl, C_RUN); end
    checks++; if (stall_cnt !== 8'd1) begin errors++; $display("FAIL load_use_cnt got %0d want 1", stall_cnt); end
    tick();
  endtask

  task automatic test_load_use_x0();
    pulse_reset();
    ex_mem_rd = 1'b1; ex_reg_wr = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    #1;
    checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL load_use_x0 got %b want %b", ctrl, C_RUN); end
    ex_rd = 5'd6; id_rs1 = 5'd1; id_rs2 = 5'd6; id_use_rs2 = 1'b0;
    #1;
    checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL load_use_unused_rs2 got %b want %b", ctrl, C_RUN); end
    id_use_rs2 = 1'b1;
    #1;
    checks++; if (ctrl !== C_STALL) begin errors++; $display("FAIL load_use_rs2 got %b want %b", ctrl, C_STALL); end
    idle_inputs();
    tick();
    checks++; if (stall_cnt !== 8'd0) begin errors++; $display("FAIL load_use_x0_cnt got %0d want 0", stall_cnt); end
  endtask

  task automatic test_redirect();
    pulse_reset();
    ex_redirect = 1'b1;
    ex_mem_rd = 1'b1; ex_reg_wr = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
    #1;
    checks++; if (ctrl !== C_REDIR) begin errors++; $display("FAIL redirect_ctrl got %b want %b", ctrl, C_REDIR); end
    tick();
    idle_inputs();
    ex_redirect = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
    #1;
    checks++; if (ctrl !== C_FREEZE) begin errors++; $display("FAIL redirect_in_freeze got %b want %b", ctrl, C_FREEZE); end
    tick();
    dmem_ready = 1'b1;
    #1;
    checks++; if (ctrl !== C_REDIR) begin errors++; $display("FAIL redirect_after_freeze got %b want %b", ctrl, C_REDIR); end
    tick();
    idle_inputs();
    #1;
    checks++; if (stall_cnt !== 8'd1) begin errors++; $display("FAIL redirect_cnt got %0d want 1", stall_cnt); end
  endtask

  task automatic test_mem_wait();
    pulse_reset();
    dmem_req = 1'b1; dmem_ready = 1'b1;
    #1;
    checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL zero_wait_ctrl got %b want %b", ctrl, C_RUN); end
    tick();
    dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctrl !== C_FREEZE) begin errors++; $display("FAIL mem_wait_%0d got %b want %b", i, ctrl, C_FREEZE); end
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL mem_done_ctrl got %b want %b", ctrl, C_RUN); end
    tick();
    idle_inputs();
    #1;
    checks++; if (stall_cnt !== 8'd3) begin errors++; $display("FAIL mem_wait_cnt got %0d want 3", stall_cnt); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL mem_wait_halted got %b want 0", halted); end
  endtask

  task automatic test_timeout();
    pulse_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 1; i <= TMO; i++) begin
      #1;
      checks++; if (halted !== 1'b0 || ctrl !== C_FREEZE) begin
        errors++; $display("FAIL timeout_wait_%0d got halted=%b ctrl=%b want 0 %b", i, halted, ctrl, C_FREEZE);
      end
      tick();
    end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL timeout_halted got %b want 1", halted); end
    checks++; if (stall_cnt !== 8'(TMO)) begin errors++; $display("FAIL timeout_cnt got %0d want %0d", stall_cnt, TMO); end
    dmem_req = 1'b0; dmem_ready = 1'b1; ex_redirect = 1'b1;
    tick();
    tick();
    checks++; if (ctrl !== C_HALT) begin errors++; $display("FAIL halt_ctrl got %b want %b", ctrl, C_HALT); end
    checks++; if (stall_cnt !== 8'(TMO + 2)) begin errors++; $display("FAIL halt_cnt got %0d want %0d", stall_cnt, TMO + 2); end
    pulse_reset();
    checks++; if (halted !== 1'b0 || ctrl !== C_RUN) begin
      errors++; $display("FAIL halt_reset got halted=%b ctrl=%b want 0 %b", halted, ctrl, C_RUN);
    end
  endtask

  task automatic test_reset_mid_wait();
    pulse_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < TMO - 2; i++) tick();
    rst_n = 1'b0;
    #1;
    checks++; if (ctrl !== C_HALT) begin errors++; $display("FAIL mid_wait_reset got %b want %b", ctrl, C_HALT); end
    rst_n = 1'b1;
    model_reset();
    #1;
    for (int i = 1; i <= TMO - 1; i++) tick();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL mid_wait_residue got halted=%b want 0", halted); end
    tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL mid_wait_fresh_timeout got halted=%b want 1", halted); end
    pulse_reset();
  endtask

  task automatic test_forwarding();
    logic [1:0] exp_a;
    logic [6:0] exp_c;
    pulse_reset();
    ex_rs1 = 5'd7; ex_rs2 = 5'd7; mem_rd = 5'd7; wb_rd = 5'd7; mem_reg_wr = 1'b1; wb_reg_wr = 1'b1;
`ifdef FORWARDING_EN
    exp_a = 2'b10;
`else
    exp_a = 2'b00;
`endif
    #1;
    checks++; if (fwd_a !== exp_a || fwd_b !== exp_a) begin
      errors++; $display("FAIL fwd_exmem got %b/%b want %b", fwd_a, fwd_b, exp_a);
    end
    mem_reg_wr = 1'b0;
`ifdef FORWARDING_EN
    exp_a = 2'b01;
`endif
    #1;
    checks++; if (fwd_a !== exp_a) begin errors++; $display("FAIL fwd_memwb got %b want %b", fwd_a, exp_a); end
    ex_rs1 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; mem_reg_wr = 1'b1;
    #1;
    checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL fwd_x0 got %b want 00", fwd_a); end
    idle_inputs();
    mem_rd = 5'd7; mem_reg_wr = 1'b1; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
`ifdef FORWARDING_EN
    exp_c = C_RUN;
`else
    exp_c = C_STALL;
`endif
    #1;
    checks++; if (ctrl !== exp_c) begin errors++; $display("FAIL raw_mem_in_id got %b want %b", ctrl, exp_c); end
    mem_reg_wr = 1'b0; wb_rd = 5'd7; wb_reg_wr = 1'b1;
    #1;
    checks++; if (ctrl !== C_RUN) begin errors++; $display("FAIL raw_wb_in_id got %b want %b", ctrl, C_RUN); end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [6:0] exp_c;
    pulse_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        #1;
        checks++; if (ctrl !== C_HALT || stall_cnt !== '0) begin
          errors++; $display("FAIL rand_reset n=%0d got ctrl=%b cnt=%0d", n, ctrl, stall_cnt);
        end
        rst_n = 1'b1;
        model_reset();
      end
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      ex_rs1 = 5'($urandom_range(0, 7)); ex_rs2 = 5'($urandom_range(0, 7));
      ex_rd  = 5'($urandom_range(0, 7)); mem_rd = 5'($urandom_range(0, 7));
      wb_rd  = 5'($urandom_range(0, 7));
      id_use_rs1 = ($urandom_range(0, 1) == 1); id_use_rs2 = ($urandom_range(0, 1) == 1);
      ex_mem_rd  = ($urandom_range(0, 3) == 0);
      ex_reg_wr  = ex_mem_rd | ($urandom_range(0, 1) == 1);
      mem_reg_wr = ($urandom_range(0, 1) == 1); wb_reg_wr = ($urandom_range(0, 1) == 1);
      ex_redirect = ($urandom_range(0, 5) == 0);
      dmem_req   = ($urandom_range(0, 2) == 0);
      dmem_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_c = m_ctrl();
      checks++; if (ctrl !== exp_c) begin errors++; $display("FAIL rand_ctrl n=%0d got %b want %b", n, ctrl, exp_c); end
      checks++; if (fwd_a !== m_fwd(ex_rs1) || fwd_b !== m_fwd(ex_rs2)) begin
        errors++; $display("FAIL rand_fwd n=%0d got %b/%b want %b/%b", n, fwd_a, fwd_b, m_fwd(ex_rs1), m_fwd(ex_rs2));
      end
      checks++; if (halted !== m_halted || stall_cnt !== 8'(m_stalls)) begin
        errors++; $display("FAIL rand_state n=%0d got halted=%b cnt=%0d want %b %0d", n, halted, stall_cnt, m_halted, m_stalls);
      end
      tick();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_load_use_x0();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_forwarding();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencer for the 5-stage RV32I core. It sits beside the control decoder and drives the enables and flushes of the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves load-use hazards, taken branches and jumps, and multi-cycle data-memory accesses. It also generates the EX-stage forwarding selects and keeps a stall-cycle performance counter.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum consecutive data-memory wait cycles before the block halts the core.
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous reset, active low.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1 / rs2.
- ex_rs1, ex_rs2  in  5 each  source registers of the instruction in EX.
- ex_rd  in  5  destination register in EX.
- ex_reg_wr, ex_mem_rd  in  1 each  EX instruction writes a register / is a load.
- mem_rd  in  5  destination register in MEM.
- mem_reg_wr  in  1  MEM instruction writes a register.
- wb_rd  in  5  destination register in WB.
- wb_reg_wr  in  1  WB instruction writes a register.
- ex_redirect  in  1  taken branch or jump resolved in EX.
- dmem_req  in  1  MEM stage is issuing a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  register update enables.
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  insert a bubble (all control bits cleared).
- fwd_a, fwd_b  out  2 each  ALU operand select: 00 register file, 10 from EX/MEM, 01 from MEM/WB.
- halted  out  1  sticky memory-timeout error.
- stall_cnt  out  CNT_W  number of cycles with pc_en low.

## Operation
- The FSM has three states: RUN, MEM_WAIT and HALT.
- Transitions:
  - RUN→MEM_WAIT when dmem_req=1 and dmem_ready=0.
  - MEM_WAIT→RUN when dmem_ready=1.
  - MEM_WAIT→HALT when wait_cnt reaches MEM_TIMEOUT with dmem_ready=0.
  - HALT is left only by reset.
- wait_cnt clears in RUN and increments each cycle spent in MEM_WAIT.
- Freeze: dmem_req & !dmem_ready, in any state except HALT.
  - pc_en, if_id_en, id_ex_en and ex_mem_en are all 0.
  - mem_wb_flush is 1.
- Redirect (no freeze, ex_redirect=1): if_id_flush=1 and id_ex_flush=1, all enables 1.
- Load-use stall (no freeze, no redirect): ex_mem_rd=1, ex_rd≠0, and ex_rd equals an id_rs* whose id_use_rs* is set.
  - pc_en=0 and if_id_en=0.
  - id_ex_flush=1.
- Priority order: HALT > freeze > redirect > load-use. A redirect during a freeze is held in EX and is acted on in the first cycle after the freeze ends.
- HALT: all enables 0, all flushes 1, halted=1.
- Forwarding, per operand:
  - 10 if mem_reg_wr, mem_rd≠0 and mem_rd==ex_rs*.
  - Otherwise 01 if wb_reg_wr, wb_rd≠0 and wb_rd==ex_rs*.
  - Otherwise 00.
  - The EX/MEM match takes precedence over the MEM/WB match.
- Register x0 never causes a hazard or a forward.
- stall_cnt increments on every cycle with pc_en=0, including HALT, and saturates at all-ones.

## Timing
- Enables, flushes and forwarding selects are combinational from the inputs and the registered state, and are valid in the same cycle.
- The state, wait_cnt, stall_cnt and halted registers update on the rising edge of clk.
- Reset (rst_n low, asynchronous):
  - state=RUN, wait_cnt=0, stall_cnt=0, halted=0.
  - All enables forced to 0, all flushes forced to 1, fwd_a=fwd_b=00.
- The first edge after release behaves as RUN.
- Reset asserted in the middle of a wait abandons the access with no residue.
- Load-use costs exactly 1 bubble. A redirect costs 2 bubbles.
- A zero-wait access (dmem_req and dmem_ready together) costs 0 cycles and does not leave RUN.
- A wait of N cycles freezes the pipeline for N cycles. HALT is entered on the edge after MEM_TIMEOUT wait cycles.

## Configuration
- FORWARDING_EN defined: behaviour exactly as described above.
- FORWARDING_EN undefined:
  - fwd_a and fwd_b are tied to 00.
  - Load-use detection extends to any RAW dependency: a stall occurs when an ID source matches ex_rd (with ex_reg_wr) or mem_rd (with mem_reg_wr), rd≠0.
  - WB never stalls, because the register file writes in the first half-cycle.

## Structure
- Shared package core_pkg holds:
  - the FSM state enum (RUN, MEM_WAIT, HALT);
  - the forwarding-select constants FWD_RF, FWD_EXMEM, FWD_MEMWB;
  - the register-index width constant.
- Sub-module fwd_unit contains the pure combinational operand-select logic, instantiated once per operand. It is omitted when FORWARDING_EN is undefined.

## Test plan
- Load-use: lw x5 in EX, ID add uses x5 → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1.
- Load-use on x0: same as above with rd=x0 → no stall.
- Redirect: ex_redirect=1 for one cycle → if_id_flush=1 and id_ex_flush=1 in that cycle; pc_en=1.
- Memory wait: dmem_req=1 with dmem_ready low for 3 cycles → 3 freeze cycles with mem_wb_flush=1, then RUN; stall_cnt=3.
- Timeout: dmem_ready held low → halted=1 after 15 cycles; everything stays frozen until rst_n pulses.
- Forwarding (FORWARDING_EN defined): mem_rd=wb_rd=ex_rs1=x7 with both writes enabled → fwd_a=10. Undefined: the same dependency seen in ID stalls instead.
